// File: rtl/mips_cp0_pkg.sv
// Shared CP0 register numbers, bit positions, sequencer states and the default handler address.
`default_nettype none

package mips_cp0_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO  = 10;
  localparam int IM_HI  = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAKE = 2'd1,
    S_RET  = 2'd2
  } seq_state_e;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;
endpackage

`default_nettype wire

// File: rtl/cp0_regs.sv
// CP0 SR/Cause/EPC storage with the MTC0 write port, MFC0 read mux and hardware EPC/EXL updates.
`default_nettype none

module cp0_regs
  import mips_cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  HWInt,
  input  logic        we,
  input  logic [4:0]  wsel,
  input  logic [31:0] wd,
  input  logic [4:0]  rsel,
  output logic [31:0] rd,
  input  logic        hw_take,
  input  logic [29:0] hw_epc,
  input  logic        hw_ret,
  output logic [5:0]  im,
  output logic        ie,
  output logic        exl,
  output logic [29:0] epc
);

  logic [5:0] ip;

  always_ff @(posedge clk) begin
    if (!rst) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
      ip  <= '0;
      epc <= '0;
    end else begin
      ip <= HWInt;
      if (we && wsel == CP0_SR) begin
        im  <= wd[IM_HI:IM_LO];
        exl <= wd[SR_EXL];
        ie  <= wd[SR_IE];
      end
      if (we && wsel == CP0_EPC)
        epc <= wd[31:2];
      // Hardware updates are ordered last so they override a simultaneous MTC0.
      if (hw_take) begin
        epc <= hw_epc;
        exl <= 1'b1;
      end
      if (hw_ret)
        exl <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    case (rsel)
      CP0_SR: begin
        rd[IM_HI:IM_LO] = im;
        rd[SR_EXL]      = exl;
        rd[SR_IE]       = ie;
      end
      CP0_CAUSE: rd[IM_HI:IM_LO] = ip;
      CP0_EPC:   rd[31:2]        = epc;
      default:   rd = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/int_sequencer.sv
// Interrupt / ERET sequencer: picks a safe take point in EX, flushes younger stages, redirects fetch.
`default_nettype none

module int_sequencer
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  HWInt,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [29:0] ex_pc,
  input  logic        id_eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_wsel,
  input  logic [31:0] cp0_wd,
  input  logic [4:0]  cp0_rsel,
  output logic [31:0] cp0_rd,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  output logic        exl
);

  seq_state_e  state;
  logic [5:0]  im;
  logic        ie;
  logic [29:0] epc;
  logic        pend;
  logic        take;
  logic        ret;

  cp0_regs u_cp0 (
    .clk     (clk),
    .rst     (rst),
    .HWInt   (HWInt),
    .we      (cp0_we),
    .wsel    (cp0_wsel),
    .wd      (cp0_wd),
    .rsel    (cp0_rsel),
    .rd      (cp0_rd),
    .hw_take (take),
    .hw_epc  (ex_pc),
    .hw_ret  (ret),
    .im      (im),
    .ie      (ie),
    .exl     (exl),
    .epc     (epc)
  );

  // Detection looks at the registered SR, so a same-cycle MTC0 has no effect on it.
  assign pend = (|(HWInt & im)) & ie & ~exl;
  assign take = (state == S_IDLE) & pend & ex_valid & ~stall;
  assign ret  = (state == S_IDLE) & ~take & id_eret & ~stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      flush_ex       <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      flush_ex       <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take) begin
            state          <= S_TAKE;
            flush_if       <= 1'b1;
            flush_id       <= 1'b1;
            flush_ex       <= 1'b1;
            redirect_valid <= 1'b1;
          end else if (ret) begin
            state          <= S_RET;
            flush_if       <= 1'b1;
            redirect_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_TAKE:  redirect_pc = HANDLER_ADDR[31:2];
      S_RET:   redirect_pc = epc;
      default: redirect_pc = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: directed stimulus pushes expected redirects, a monitor checks them.
`default_nettype none

module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  HWInt;
  logic        stall;
  logic        ex_valid;
  logic [29:0] ex_pc;
  logic        id_eret;
  logic        cp0_we;
  logic [4:0]  cp0_wsel;
  logic [31:0] cp0_wd;
  logic [4:0]  cp0_rsel;
  logic [31:0] cp0_rd;
  logic        flush_if, flush_id, flush_ex;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        exl;

  typedef struct packed {
    logic        fi;
    logic        fid;
    logic        fex;
    logic [29:0] pc;
    logic        exl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  int_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .HWInt          (HWInt),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .id_eret        (id_eret),
    .cp0_we         (cp0_we),
    .cp0_wsel       (cp0_wsel),
    .cp0_wd         (cp0_wd),
    .cp0_rsel       (cp0_rsel),
    .cp0_rd         (cp0_rd),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exl            (exl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string name, input logic [4:0] sel, input logic [31:0] exp);
    cp0_rsel = sel;
    #1;
    chk(name, cp0_rd, exp);
  endtask

  task automatic quiet(input string name);
    chk(name, {28'd0, flush_if, flush_id, flush_ex, redirect_valid}, 32'd0);
  endtask

  task automatic mtc0(input logic [4:0] sel, input logic [31:0] d);
    cp0_we = 1'b1; cp0_wsel = sel; cp0_wd = d;
    tick();
    cp0_we = 1'b0;
  endtask

  function automatic exp_t e_take(input logic [29:0] pc);
    return '{fi: 1'b1, fid: 1'b1, fex: 1'b1, pc: pc, exl: 1'b1};
  endfunction

  function automatic exp_t e_ret(input logic [29:0] pc);
    return '{fi: 1'b1, fid: 1'b0, fex: 1'b0, pc: pc, exl: 1'b0};
  endfunction

  // Monitor: any flush/redirect activity must match the oldest queued expectation.
  always @(negedge clk) begin
    if (redirect_valid || flush_if || flush_id || flush_ex) begin
      exp_t got;
      got = '{fi: flush_if, fid: flush_id, fex: flush_ex, pc: redirect_pc, exl: exl};
      n_vec++;
      if (!redirect_valid) begin
        n_err++;
        $display("FAIL flush_without_redirect: got %h expected redirect_valid=1", got);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_redirect: got %h expected no activity", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL redirect: got %h expected %h", got, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; HWInt = '0; stall = 1'b0; ex_valid = 1'b0; ex_pc = '0;
    id_eret = 1'b0; cp0_we = 1'b0; cp0_wsel = '0; cp0_wd = '0; cp0_rsel = '0;
    repeat (2) tick();
    rst = 1'b1;

    rdchk("reset_sr", 5'd12, 32'd0);
    rdchk("reset_cause", 5'd13, 32'd0);
    rdchk("reset_epc", 5'd14, 32'd0);
    quiet("reset_outputs");
    chk("reset_exl", {31'd0, exl}, 32'd0);

    mtc0(5'd12, 32'h0000_0401);
    rdchk("sr_write", 5'd12, 32'h0000_0401);

    // Basic take
    HWInt = 6'b000001; ex_valid = 1'b1; ex_pc = 30'h0C01;
    sb.push_back(e_take(30'h1060));
    tick();
    HWInt = '0; ex_valid = 1'b0;
    rdchk("take_epc", 5'd14, 32'h0000_3004);
    chk("take_exl", {31'd0, exl}, 32'd1);
    tick();
    quiet("take_one_cycle");

    // ERET back to EPC
    id_eret = 1'b1;
    sb.push_back(e_ret(30'h0C01));
    tick();
    id_eret = 1'b0;
    chk("eret_exl", {31'd0, exl}, 32'd0);
    tick();
    quiet("eret_one_cycle");

    // Stall and bubble gating
    HWInt = 6'b000001; ex_valid = 1'b1; stall = 1'b1; ex_pc = 30'h0777;
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet("stall_gate");
    end
    stall = 1'b0; ex_valid = 1'b0;
    tick();
    quiet("bubble_gate");
    ex_valid = 1'b1; ex_pc = 30'h0123;
    sb.push_back(e_take(30'h1060));
    tick();
    HWInt = '0; ex_valid = 1'b0;
    rdchk("gated_epc", 5'd14, 32'h0000_048C);
    tick();
    id_eret = 1'b1;
    sb.push_back(e_ret(30'h0123));
    tick();
    id_eret = 1'b0;
    tick();

    // Masking: IM=0, then IE=0, then EXL=1
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'b111111; ex_valid = 1'b1; ex_pc = 30'h0555;
    tick(); tick();
    quiet("mask_im");
    rdchk("cause_ip", 5'd13, 32'h0000_FC00);
    mtc0(5'd12, 32'h0000_FC00);
    tick();
    quiet("mask_ie");
    mtc0(5'd12, 32'h0000_FC03);
    tick();
    quiet("mask_exl");
    chk("mask_exl_out", {31'd0, exl}, 32'd1);
    rdchk("mask_epc_kept", 5'd14, 32'h0000_048C);

    // Interrupt wins over ERET; hardware EPC load wins over MTC0 EPC
    HWInt = '0; ex_valid = 1'b0;
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ex_valid = 1'b1; ex_pc = 30'h0200; id_eret = 1'b1;
    cp0_we = 1'b1; cp0_wsel = 5'd14; cp0_wd = 32'hDEAD_0000;
    sb.push_back(e_take(30'h1060));
    tick();
    cp0_we = 1'b0; id_eret = 1'b0; HWInt = '0; ex_valid = 1'b0;
    chk("conflict_exl", {31'd0, exl}, 32'd1);
    rdchk("conflict_epc", 5'd14, 32'h0000_0800);
    tick();
    quiet("conflict_one_cycle");
    id_eret = 1'b1;
    sb.push_back(e_ret(30'h0200));
    tick();
    id_eret = 1'b0;
    tick();

    // Reset during S_TAKE abandons the redirect
    HWInt = 6'b000001; ex_valid = 1'b1; ex_pc = 30'h0300;
    sb.push_back(e_take(30'h1060));
    tick();
    HWInt = '0; ex_valid = 1'b0; rst = 1'b0;
    tick();
    quiet("rst_in_take");
    chk("rst_in_take_exl", {31'd0, exl}, 32'd0);
    rdchk("rst_in_take_epc", 5'd14, 32'd0);
    rst = 1'b1;
    tick(); tick();
    quiet("after_reset_idle");

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
